// File: rtl/div_sp_pkg.sv
// Shared constants, FSM encoding and operand classes for the binary32 divider front-end.
package div_sp_pkg;

  localparam int EXP_W = 10;
  localparam int MAN_W = 24;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [30:0] INF  = 31'h7F80_0000;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_NORM     = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_class_t;

endpackage

// File: rtl/fp_classify_sp.sv
// Combinational binary32 magnitude classifier: class, unbiased exponent, 24-bit mantissa.
// Subnormals become CLS_SUB under DIV_PREP_DENORM_EN, otherwise they read as zero.
module fp_classify_sp
  import div_sp_pkg::*;
(
  input  logic [30:0]      i_mag,
  output op_class_t        o_cls,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-1:0] o_man
);

  logic [7:0]  w_e;
  logic [22:0] w_f;

  assign w_e = i_mag[30:23];
  assign w_f = i_mag[22:0];

  always_comb begin
    o_cls = CLS_ZERO;
    o_exp = '0;
    o_man = '0;
    if (w_e == 8'hFF) begin
      o_cls = (w_f == '0) ? CLS_INF : CLS_NAN;
    end else if (w_e != 8'h00) begin
      o_cls = CLS_NORM;
      o_exp = EXP_W'(w_e) - EXP_W'(BIAS);
      o_man = {1'b1, w_f};
    end else if (w_f != '0) begin
`ifdef DIV_PREP_DENORM_EN
      // Subnormals share the minimum normal exponent; hidden bit is 0.
      o_cls = CLS_SUB;
      o_exp = EXP_W'(1 - BIAS);
      o_man = {1'b0, w_f};
`else
      o_cls = CLS_ZERO;
`endif
    end
  end

endmodule

// File: rtl/div_sp_operand_prep.sv
// Divider front-end: captures binary32 a/b, resolves IEEE specials, normalizes operands.
// DIV_PREP_DENORM_EN builds the NORM shifter for subnormals; undefined gives denormals-are-zero.
module div_sp_operand_prep
  import div_sp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_strt,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp_a,
  output logic [EXP_W-1:0] o_exp_b,
  output logic [MAN_W-1:0] o_man_a,
  output logic [MAN_W-1:0] o_man_b,
  output logic             o_special,
  output logic [31:0]      o_special_z
);

  logic [1:0]       r_state;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_sign;
  logic [EXP_W-1:0] r_exp_a;
  logic [EXP_W-1:0] r_exp_b;
  logic [MAN_W-1:0] r_man_a;
  logic [MAN_W-1:0] r_man_b;
  logic             r_special;
  logic [31:0]      r_special_z;

  op_class_t        w_cls_a;
  op_class_t        w_cls_b;
  logic [EXP_W-1:0] w_exp_a;
  logic [EXP_W-1:0] w_exp_b;
  logic [MAN_W-1:0] w_man_a;
  logic [MAN_W-1:0] w_man_b;
  logic             w_sign;
  logic             w_special;
  logic [31:0]      w_special_z;

  fp_classify_sp u_cls_a (.i_mag(r_a[30:0]), .o_cls(w_cls_a), .o_exp(w_exp_a), .o_man(w_man_a));
  fp_classify_sp u_cls_b (.i_mag(r_b[30:0]), .o_cls(w_cls_b), .o_exp(w_exp_b), .o_man(w_man_b));

  assign w_sign = r_a[31] ^ r_b[31];

  // First matching rule wins; QNAN is always emitted with a positive sign.
  always_comb begin
    w_special   = 1'b1;
    w_special_z = QNAN;
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN) begin
      w_special_z = QNAN;
    end else if ((w_cls_a == CLS_INF && w_cls_b == CLS_INF) ||
                 (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO)) begin
      w_special_z = QNAN;
    end else if (w_cls_a == CLS_INF) begin
      w_special_z = {w_sign, INF};
    end else if (w_cls_b == CLS_INF) begin
      w_special_z = {w_sign, 31'd0};
    end else if (w_cls_b == CLS_ZERO) begin
      w_special_z = {w_sign, INF};
    end else if (w_cls_a == CLS_ZERO) begin
      w_special_z = {w_sign, 31'd0};
    end else begin
      w_special   = 1'b0;
      w_special_z = '0;
    end
  end

`ifdef DIV_PREP_DENORM_EN
  logic [MAN_W-1:0] w_man_a_sh;
  logic [MAN_W-1:0] w_man_b_sh;
  logic [EXP_W-1:0] w_exp_a_sh;
  logic [EXP_W-1:0] w_exp_b_sh;

  // One normalization step per cycle; an already-normalized operand holds.
  always_comb begin
    w_man_a_sh = r_man_a;
    w_exp_a_sh = r_exp_a;
    w_man_b_sh = r_man_b;
    w_exp_b_sh = r_exp_b;
    if (!r_man_a[MAN_W-1]) begin
      w_man_a_sh = {r_man_a[MAN_W-2:0], 1'b0};
      w_exp_a_sh = r_exp_a - EXP_W'(1);
    end
    if (!r_man_b[MAN_W-1]) begin
      w_man_b_sh = {r_man_b[MAN_W-2:0], 1'b0};
      w_exp_b_sh = r_exp_b - EXP_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_man_a     <= '0;
      r_man_b     <= '0;
      r_special   <= 1'b0;
      r_special_z <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_strt) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          r_sign      <= w_sign;
          r_special   <= w_special;
          r_special_z <= w_special_z;
          if (w_special) begin
            r_exp_a <= '0;
            r_exp_b <= '0;
            r_man_a <= '0;
            r_man_b <= '0;
            r_state <= S_HOLD;
          end else begin
            r_exp_a <= w_exp_a;
            r_exp_b <= w_exp_b;
            r_man_a <= w_man_a;
            r_man_b <= w_man_b;
`ifdef DIV_PREP_DENORM_EN
            r_state <= (w_man_a[MAN_W-1] && w_man_b[MAN_W-1]) ? S_HOLD : S_NORM;
`else
            r_state <= S_HOLD;
`endif
          end
        end
`ifdef DIV_PREP_DENORM_EN
        S_NORM: begin
          r_man_a <= w_man_a_sh;
          r_man_b <= w_man_b_sh;
          r_exp_a <= w_exp_a_sh;
          r_exp_b <= w_exp_b_sh;
          if (w_man_a_sh[MAN_W-1] && w_man_b_sh[MAN_W-1]) begin
            r_state <= S_HOLD;
          end
        end
`endif
        S_HOLD: begin
          if (i_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_valid     = (r_state == S_HOLD);
  assign o_sign      = r_sign;
  assign o_exp_a     = r_exp_a;
  assign o_exp_b     = r_exp_b;
  assign o_man_a     = r_man_a;
  assign o_man_b     = r_man_b;
  assign o_special   = r_special;
  assign o_special_z = r_special_z;

endmodule

// File: tb/tb_div_sp_operand_prep.sv
// Self-checking bench for div_sp_operand_prep: directed IEEE cases plus random operand pairs
// checked against a value-level reference model.
module tb_div_sp_operand_prep;

  localparam int C_ZERO = 0;
  localparam int C_NUM  = 1;
  localparam int C_INF  = 2;
  localparam int C_NAN  = 3;

  typedef struct {
    logic        sign;
    logic [9:0]  exp_a;
    logic [9:0]  exp_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        special;
    logic [31:0] z;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        i_strt;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [9:0]  o_exp_a;
  logic [9:0]  o_exp_b;
  logic [23:0] o_man_a;
  logic [23:0] o_man_b;
  logic        o_special;
  logic [31:0] o_special_z;

  int n_cmp  = 0;
  int n_fail = 0;

  div_sp_operand_prep dut (
    .clk(clk), .reset(reset), .i_strt(i_strt), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign),
    .o_exp_a(o_exp_a), .o_exp_b(o_exp_b), .o_man_a(o_man_a), .o_man_b(o_man_b),
    .o_special(o_special), .o_special_z(o_special_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Operand value as class, exponent and mantissa, derived from the number it represents.
  function automatic void decode(input logic [31:0] w, output int cls, output int e,
                                 output int m, output int sh);
    int ex;
    int fr;
    ex = int'(w[30:23]);
    fr = int'(w[22:0]);
    cls = C_ZERO; e = 0; m = 0; sh = 0;
    if (ex == 255) begin
      cls = (fr == 0) ? C_INF : C_NAN;
    end else if (ex != 0) begin
      cls = C_NUM; e = ex - 127; m = fr + (1 << 23);
    end else if (fr != 0) begin
`ifdef DIV_PREP_DENORM_EN
      int p;
      p = 0;
      for (int i = 0; i < 23; i++) if (((fr >> i) & 1) == 1) p = i;
      // value = fr * 2^-149 = 1.xxx * 2^(p-149)
      cls = C_NUM; e = p - 149; sh = 23 - p; m = fr << sh;
`else
      cls = C_ZERO;
`endif
    end
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ca, ea, ma, sa, cb, eb, mb, sb;
    decode(a, ca, ea, ma, sa);
    decode(b, cb, eb, mb, sb);
    r.sign = a[31] ^ b[31];
    r.special = 1'b1; r.lat = 2;
    r.exp_a = '0; r.exp_b = '0; r.man_a = '0; r.man_b = '0;
    if (ca == C_NAN || cb == C_NAN)                                  r.z = 32'h7FC0_0000;
    else if ((ca == C_INF && cb == C_INF) || (ca == C_ZERO && cb == C_ZERO)) r.z = 32'h7FC0_0000;
    else if (ca == C_INF)  r.z = {r.sign, 8'hFF, 23'd0};
    else if (cb == C_INF)  r.z = {r.sign, 31'd0};
    else if (cb == C_ZERO) r.z = {r.sign, 8'hFF, 23'd0};
    else if (ca == C_ZERO) r.z = {r.sign, 31'd0};
    else begin
      r.special = 1'b0; r.z = '0;
      r.exp_a = 10'(ea); r.exp_b = 10'(eb);
      r.man_a = 24'(ma); r.man_b = 24'(mb);
      r.lat = 2 + ((sa > sb) ? sa : sb);
    end
    return r;
  endfunction

  task automatic check_out(input exp_t e, input string tag);
    chk({tag, ".sign"},    32'(o_sign),    32'(e.sign));
    chk({tag, ".exp_a"},   32'(o_exp_a),   32'(e.exp_a));
    chk({tag, ".exp_b"},   32'(o_exp_b),   32'(e.exp_b));
    chk({tag, ".man_a"},   32'(o_man_a),   32'(e.man_a));
    chk({tag, ".man_b"},   32'(o_man_b),   32'(e.man_b));
    chk({tag, ".special"}, 32'(o_special), 32'(e.special));
    chk({tag, ".z"},       o_special_z,    e.z);
  endtask

  // Starts one operation from IDLE at a negedge, stalls i_ready for 'stall' cycles while
  // pulsing i_strt, then completes the handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                       input string tag);
    exp_t e;
    int   lat;
    e = model(a, b);
    i_a = a; i_b = b; i_strt = 1'b1; i_ready = (stall == 0);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); @(negedge clk);
      i_strt = 1'b0;
      if (o_valid) lat = n;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    check_out(e, tag);
    for (int k = 0; k < stall; k++) begin
      i_strt = 1'b1;
      i_a = $urandom; i_b = $urandom;
      @(posedge clk); @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
      check_out(e, {tag, ".hold"});
    end
    i_strt = 1'b0; i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, ".done_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".done_busy"},  32'(o_busy),  32'd0);
    i_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [22:0] f;
    int          e;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: begin
        f = 23'($urandom) >> $urandom_range(0, 22);
        w = {w[31], 8'h00, f};
      end
      2: begin
        case ($urandom_range(0, 2))
          0: w = {w[31], 31'd0};
          1: w = {w[31], 8'hFF, 23'd0};
          default: w = {w[31], 8'hFF, 1'b1, w[21:0]};
        endcase
      end
      default: begin
        e = $urandom_range(1, 254);
        w = {w[31], 8'(e), w[22:0]};
      end
    endcase
    return w;
  endfunction

  initial begin
    exp_t e;
    int   nval;
    int   quiet;
    reset = 1'b1; i_strt = 1'b0; i_a = '0; i_b = '0; i_ready = 1'b0;
    #1;
    chk("rst.busy",  32'(o_busy),  32'd0);
    chk("rst.valid", 32'(o_valid), 32'd0);
    e = '{sign: 1'b0, exp_a: '0, exp_b: '0, man_a: '0, man_b: '0, special: 1'b0, z: '0, lat: 0};
    check_out(e, "rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'h40C0_0000, 32'h4000_0000, 0, "c1");
    do_op(32'h0000_0001, 32'h3F80_0000, 0, "c2");
    do_op(32'h0000_0000, 32'h8000_0000, 0, "sp_zz");
    do_op(32'h3F80_0000, 32'h8000_0000, 0, "sp_x0");
    do_op(32'h7F80_0000, 32'h4000_0000, 0, "sp_ix");
    do_op(32'h4000_0000, 32'hFF80_0000, 0, "sp_xi");
    do_op(32'h7FC0_0001, 32'h3F80_0000, 0, "sp_nan");
    do_op(32'h7F80_0000, 32'hFF80_0000, 0, "sp_ii");
    do_op(32'h8000_0000, 32'h3F80_0000, 0, "sp_0x");
    do_op(32'h0040_0000, 32'h0000_0300, 1, "sub2");
    do_op(32'h40C0_0000, 32'h4000_0000, 5, "bp");

    // Reset in the middle of an operation.
    i_a = 32'h0000_0001; i_b = 32'h3F80_0000; i_strt = 1'b1; i_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); @(negedge clk);
      i_strt = 1'b0;
    end
    chk("mid.busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.rst_busy",  32'(o_busy),  32'd0);
    chk("mid.rst_valid", 32'(o_valid), 32'd0);
    e = '{sign: 1'b0, exp_a: '0, exp_b: '0, man_a: '0, man_b: '0, special: 1'b0, z: '0, lat: 0};
    check_out(e, "mid.rst");
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid || o_busy) quiet++;
    end
    chk("mid.no_pulse", 32'(quiet), 32'd0);
    do_op(32'h40C0_0000, 32'h4000_0000, 0, "post_rst");

    // Back-to-back with i_strt held high.
    i_a = 32'h40C0_0000; i_b = 32'h4000_0000; i_strt = 1'b1; i_ready = 1'b1;
    nval = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) begin
        nval++;
        chk("b2b.phase", 32'(n % 3), 32'd2);
        chk("b2b.man_a", 32'(o_man_a), 32'h00C0_0000);
      end
    end
    i_strt = 1'b0; i_ready = 1'b0;
    chk("b2b.count", 32'(nval), 32'd10);
    @(posedge clk); @(negedge clk);
    chk("b2b.idle", 32'(o_busy), 32'd0);

    for (int t = 0; t < 80; t++) begin
      do_op(rand_word(), rand_word(), $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
